// File: rtl/awgn_channel_adder_pkg.sv
// ============================================================================
// awgn_channel_adder_pkg
//
// Purpose:
//   Shared fixed-point definitions for the channel stages that sit behind the
//   scaled Gaussian noise generator. Holds the symbol/noise/sum/power formats
//   and the S(9,7) -> S(8,7) saturate function that every stage reuses.
//
// Contents:
//   SYM_NBT / SYM_NBF     : transmitted symbol format, S(8,7)
//   NOISE_NBT / NOISE_NBF : noise sample format, S(8,7)
//   SUM_NBT               : full-resolution symbol+noise width, S(9,7)
//   POW_NBT               : nI^2+nQ^2 width, U(17,14)
//   sat_result_t          : saturated value plus a "was clipped" flag
//   saturate_sum()        : S(SUM_NBT,F) -> S(SYM_NBT,F) with clip detection
// ============================================================================
package awgn_channel_adder_pkg;

    localparam int SYM_NBT   = 8;
    localparam int SYM_NBF   = 7;
    localparam int NOISE_NBT = 8;
    localparam int NOISE_NBF = 7;
    localparam int SUM_NBT   = SYM_NBT + 1;
    localparam int POW_NBT   = 2 * NOISE_NBT + 1;

    // Largest positive and most negative codes of the symbol format.
    localparam logic [SYM_NBT-1:0] SYM_MAX = {1'b0, {(SYM_NBT-1){1'b1}}};
    localparam logic [SYM_NBT-1:0] SYM_MIN = {1'b1, {(SYM_NBT-1){1'b0}}};

    typedef struct packed {
        logic [SYM_NBT-1:0] value;
        logic               clipped;
    } sat_result_t;

    // One guard bit above the symbol format: if the guard bit and the symbol
    // MSB disagree the value left the representable range, and the guard bit
    // (the true sign) picks which rail to clip to.
    function automatic sat_result_t saturate_sum(input logic [SUM_NBT-1:0] sum);
        sat_result_t res;
        if (sum[SUM_NBT-1] != sum[SUM_NBT-2]) begin
            res.value   = sum[SUM_NBT-1] ? SYM_MIN : SYM_MAX;
            res.clipped = 1'b1;
        end else begin
            res.value   = sum[SYM_NBT-1:0];
            res.clipped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/awgn_pow_meter.sv
// ============================================================================
// awgn_pow_meter
//
// Purpose:
//   Averages the instantaneous noise power nI^2+nQ^2 over windows of
//   2^LOG2_WIN samples so the programmed noise sigma can be read back.
//   The mean is a plain right shift of the window sum, so the output keeps
//   the U(17,14) format of the input power.
//
// Ports:
//   i_clock      : system clock
//   i_reset      : asynchronous active-low reset
//   i_valid      : one power sample presented this cycle
//   i_pow        : power sample, U(NBT_POW,14)
//   i_clr        : synchronous clear of accumulator and window counter
//   o_noise_pow  : mean power of the last completed window
//   o_pow_valid  : one-cycle pulse when o_noise_pow updates
// ============================================================================
module awgn_pow_meter #(
    parameter int LOG2_WIN = 10,
    parameter int NBT_POW  = 17
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NBT_POW-1:0] i_pow,
    input  logic               i_clr,
    output logic [NBT_POW-1:0] o_noise_pow,
    output logic               o_pow_valid
);

    // Sized so a full window of maximum-power samples cannot overflow.
    localparam int NBT_ACC = NBT_POW + LOG2_WIN;

    logic [NBT_ACC-1:0]  acc;
    logic [NBT_ACC-1:0]  acc_next;
    logic [LOG2_WIN-1:0] win_cnt;
    logic                win_last;

    // The closing sample is folded in combinationally so the mean is
    // published in the same cycle the window completes.
    assign acc_next = acc + NBT_ACC'(i_pow);
    assign win_last = &win_cnt;

    // Accumulate samples; on the last sample of a window publish the mean
    // and restart from zero. Clear takes priority over a sample arriving in
    // the same cycle. The window counter wraps back to zero on its own.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc         <= '0;
            win_cnt     <= '0;
            o_noise_pow <= '0;
            o_pow_valid <= 1'b0;
        end else begin
            o_pow_valid <= 1'b0;
            if (i_clr) begin
                acc     <= '0;
                win_cnt <= '0;
            end else if (i_valid) begin
                win_cnt <= win_cnt + LOG2_WIN'(1);
                if (win_last) begin
                    o_noise_pow <= acc_next[NBT_ACC-1:LOG2_WIN];
                    o_pow_valid <= 1'b1;
                    acc         <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/awgn_channel_adder.sv
// ============================================================================
// awgn_channel_adder
//
// Purpose:
//   Channel stage directly after the scaled Gaussian noise generator. Adds
//   independent I/Q noise to the transmitted I/Q symbols, saturates the
//   result back to the symbol format through a two-stage pipeline, counts
//   clipped output components and measures mean noise power per window.
//
// Ports:
//   i_clock          : system clock
//   i_reset          : asynchronous active-low reset
//   i_enable         : symbol-rate strobe
//   i_sym_valid      : TX symbols valid (accept = i_enable && i_sym_valid)
//   i_symbI/Q        : TX symbol, S(8,7)
//   i_noise_I/Q      : noise sample, S(8,7)
//   i_noise_valid_I/Q: noise samples valid
//   i_noise_on       : 0 forces the noise to zero (bypass)
//   i_clr_stats      : clears clip counter and power window
//   o_symbI/Q        : noisy symbol, S(8,7), held between samples
//   o_valid          : one-cycle pulse, two cycles after each accept
//   o_noise_pow      : mean of nI^2+nQ^2 over the window, U(17,14)
//   o_pow_valid      : one-cycle pulse when o_noise_pow updates
//   o_sat_count      : saturating count of clipped output components
// ============================================================================
module awgn_channel_adder
    import awgn_channel_adder_pkg::*;
#(
    parameter int NBT_SYM    = SYM_NBT,
    parameter int NBF_SYM    = SYM_NBF,
    parameter int NBT_NOISE  = NOISE_NBT,
    parameter int NBF_NOISE  = NOISE_NBF,
    parameter int LOG2_WIN   = 10,
    parameter int NBT_SATCNT = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_sym_valid,
    input  logic [NBT_SYM-1:0]     i_symbI,
    input  logic [NBT_SYM-1:0]     i_symbQ,
    input  logic [NBT_NOISE-1:0]   i_noise_I,
    input  logic [NBT_NOISE-1:0]   i_noise_Q,
    input  logic                   i_noise_valid_I,
    input  logic                   i_noise_valid_Q,
    input  logic                   i_noise_on,
    input  logic                   i_clr_stats,
    output logic [NBT_SYM-1:0]     o_symbI,
    output logic [NBT_SYM-1:0]     o_symbQ,
    output logic                   o_valid,
    output logic [2*NBT_NOISE:0]   o_noise_pow,
    output logic                   o_pow_valid,
    output logic [NBT_SATCNT-1:0]  o_sat_count
);

    localparam int NBT_SUM = NBT_SYM + 1;
    localparam int NBT_POW = 2 * NBT_NOISE + 1;

    // The saturate function and the squaring assume symbol and noise share
    // the package's S(8,7) format; refuse to elaborate anything else.
    if (NBT_SYM != SYM_NBT || NBF_SYM != SYM_NBF ||
        NBT_NOISE != NOISE_NBT || NBF_NOISE != NOISE_NBF ||
        NBT_POW != POW_NBT) begin : g_format_check
        $error("awgn_channel_adder: symbol/noise format must be S(8,7)");
    end

    // ------------------------------------------------------------------
    // Input qualification and noise gating
    // ------------------------------------------------------------------
    logic                        accept;
    logic                        noise_gate;
    logic signed [NBT_NOISE-1:0] noise_i;
    logic signed [NBT_NOISE-1:0] noise_q;

    assign accept     = i_enable & i_sym_valid;
    // Noise is only trusted when both components are valid together, so a
    // half-valid pair never skews one rail.
    assign noise_gate = i_noise_on & i_noise_valid_I & i_noise_valid_Q;
    assign noise_i    = noise_gate ? $signed(i_noise_I) : '0;
    assign noise_q    = noise_gate ? $signed(i_noise_Q) : '0;

    // ------------------------------------------------------------------
    // Stage-1 arithmetic: full-resolution sums and instantaneous power
    // ------------------------------------------------------------------
    logic [NBT_SUM-1:0]            sum_i_next;
    logic [NBT_SUM-1:0]            sum_q_next;
    logic signed [2*NBT_NOISE-1:0] sq_i;
    logic signed [2*NBT_NOISE-1:0] sq_q;
    logic [NBT_POW-1:0]            pow_next;

    // One extra integer bit makes the sum exact, so overflow handling is
    // deferred to stage 2.
    assign sum_i_next = {i_symbI[NBT_SYM-1], i_symbI} + {noise_i[NBT_NOISE-1], noise_i};
    assign sum_q_next = {i_symbQ[NBT_SYM-1], i_symbQ} + {noise_q[NBT_NOISE-1], noise_q};

    // Squares are non-negative (max 2^14 for -128), so zero-extending each
    // before the add gives U(17,14) without loss.
    assign sq_i     = noise_i * noise_i;
    assign sq_q     = noise_q * noise_q;
    assign pow_next = {1'b0, sq_i} + {1'b0, sq_q};

    logic               s1_valid;
    logic               s1_stat_valid;
    logic [NBT_SUM-1:0] s1_sum_i;
    logic [NBT_SUM-1:0] s1_sum_q;
    logic [NBT_POW-1:0] s1_pow;

    // Stage-1 register. s1_stat_valid drops a sample that arrives together
    // with a stats clear, so after a clear the statistics only reflect
    // samples accepted strictly later; the sample itself still flows on.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            s1_valid      <= 1'b0;
            s1_stat_valid <= 1'b0;
            s1_sum_i      <= '0;
            s1_sum_q      <= '0;
            s1_pow        <= '0;
        end else begin
            s1_valid      <= accept;
            s1_stat_valid <= accept & ~i_clr_stats;
            if (accept) begin
                s1_sum_i <= sum_i_next;
                s1_sum_q <= sum_q_next;
                s1_pow   <= pow_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturation and output register
    // ------------------------------------------------------------------
    sat_result_t sat_i;
    sat_result_t sat_q;
    logic [1:0]  clip_count;

    assign sat_i      = saturate_sum(s1_sum_i);
    assign sat_q      = saturate_sum(s1_sum_q);
    assign clip_count = {1'b0, sat_i.clipped} + {1'b0, sat_q.clipped};

    // Outputs only move on a valid stage-1 sample and otherwise hold, so the
    // downstream stage can sample o_symbI/Q at any time.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_symbI <= '0;
            o_symbQ <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_symbI <= sat_i.value;
                o_symbQ <= sat_q.value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Clip counter
    // ------------------------------------------------------------------
    logic [NBT_SATCNT:0] cnt_sum;

    // One extra bit catches the carry out so the counter can pin at all-ones
    // instead of wrapping.
    assign cnt_sum = {1'b0, o_sat_count} + {{(NBT_SATCNT-1){1'b0}}, clip_count};

    // Clear wins over a clip arriving in the same cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_sat_count <= '0;
        end else if (i_clr_stats) begin
            o_sat_count <= '0;
        end else if (s1_stat_valid) begin
            o_sat_count <= cnt_sum[NBT_SATCNT] ? {NBT_SATCNT{1'b1}}
                                               : cnt_sum[NBT_SATCNT-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Noise power meter
    // ------------------------------------------------------------------
    awgn_pow_meter #(
        .LOG2_WIN (LOG2_WIN),
        .NBT_POW  (NBT_POW)
    ) u_pow_meter (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_valid     (s1_stat_valid),
        .i_pow       (s1_pow),
        .i_clr       (i_clr_stats),
        .o_noise_pow (o_noise_pow),
        .o_pow_valid (o_pow_valid)
    );

endmodule

// File: tb/tb_awgn_channel_adder.sv
// ============================================================================
// tb_awgn_channel_adder
//
// Self-checking bench for awgn_channel_adder with a 16-sample power window.
// A cycle-level reference model built from plain integer arithmetic tracks
// the expected outputs; directed scenarios also compare against hand-derived
// constants.
// ============================================================================
module tb_awgn_channel_adder;

    localparam int LOG2_WIN = 4;
    localparam int WIN      = 16;
    localparam int SATMAX   = 65535;

    logic        clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_sym_valid = 1'b0;
    logic [7:0]  i_symbI = '0;
    logic [7:0]  i_symbQ = '0;
    logic [7:0]  i_noise_I = '0;
    logic [7:0]  i_noise_Q = '0;
    logic        i_noise_valid_I = 1'b0;
    logic        i_noise_valid_Q = 1'b0;
    logic        i_noise_on = 1'b0;
    logic        i_clr_stats = 1'b0;
    logic [7:0]  o_symbI;
    logic [7:0]  o_symbQ;
    logic        o_valid;
    logic [16:0] o_noise_pow;
    logic        o_pow_valid;
    logic [15:0] o_sat_count;

    int checks = 0;
    int errors = 0;

    // Reference model: visible outputs and statistics
    bit         m_valid;
    logic [7:0] m_i, m_q;
    int         m_cnt, m_acc, m_win, m_pow;
    bit         m_pow_valid;
    // Reference model: sample in flight between accept and output
    bit         p_valid, p_stat;
    logic [7:0] p_i, p_q;
    int         p_clips, p_pow;

    awgn_channel_adder #(
        .NBT_SYM    (8),
        .NBF_SYM    (7),
        .NBT_NOISE  (8),
        .NBF_NOISE  (7),
        .LOG2_WIN   (LOG2_WIN),
        .NBT_SATCNT (16)
    ) dut (
        .i_clock         (clock),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_sym_valid     (i_sym_valid),
        .i_symbI         (i_symbI),
        .i_symbQ         (i_symbQ),
        .i_noise_I       (i_noise_I),
        .i_noise_Q       (i_noise_Q),
        .i_noise_valid_I (i_noise_valid_I),
        .i_noise_valid_Q (i_noise_valid_Q),
        .i_noise_on      (i_noise_on),
        .i_clr_stats     (i_clr_stats),
        .o_symbI         (o_symbI),
        .o_symbQ         (o_symbQ),
        .o_valid         (o_valid),
        .o_noise_pow     (o_noise_pow),
        .o_pow_valid     (o_pow_valid),
        .o_sat_count     (o_sat_count)
    );

    always #5 clock = ~clock;

    function automatic int rand_s8();
        return int'($urandom_range(255, 0)) - 128;
    endfunction

    task automatic model_zero();
        m_valid = 0; m_i = '0; m_q = '0;
        m_cnt = 0; m_acc = 0; m_win = 0; m_pow = 0; m_pow_valid = 0;
        p_valid = 0; p_stat = 0; p_i = '0; p_q = '0; p_clips = 0; p_pow = 0;
    endtask

    // Drives one cycle of inputs, advances one clock and updates the model.
    // Returns #1 after the clock edge, where outputs are stable to sample.
    task automatic step(input bit en, input bit sv, input int si, input int sq,
                        input int ni, input int nq, input bit nvi, input bit nvq,
                        input bit non, input bit clr);
        bit acc_f, gate;
        int eni, enq, ti, tq, clips;
        i_enable = en; i_sym_valid = sv;
        i_symbI = 8'(si); i_symbQ = 8'(sq);
        i_noise_I = 8'(ni); i_noise_Q = 8'(nq);
        i_noise_valid_I = nvi; i_noise_valid_Q = nvq;
        i_noise_on = non; i_clr_stats = clr;
        acc_f = en && sv;
        gate  = non && nvi && nvq;
        eni   = gate ? ni : 0;
        enq   = gate ? nq : 0;
        ti = si + eni; tq = sq + enq; clips = 0;
        if (ti > 127) begin ti = 127; clips++; end
        else if (ti < -128) begin ti = -128; clips++; end
        if (tq > 127) begin tq = 127; clips++; end
        else if (tq < -128) begin tq = -128; clips++; end
        @(posedge clock);
        m_pow_valid = 0;
        if (clr) begin
            m_cnt = 0; m_acc = 0; m_win = 0;
        end else if (p_stat) begin
            m_cnt = (m_cnt + p_clips > SATMAX) ? SATMAX : m_cnt + p_clips;
            m_acc += p_pow;
            m_win++;
            if (m_win == WIN) begin
                m_pow = m_acc / WIN; m_pow_valid = 1; m_acc = 0; m_win = 0;
            end
        end
        m_valid = p_valid;
        if (p_valid) begin m_i = p_i; m_q = p_q; end
        p_valid = acc_f;
        p_stat  = acc_f && !clr;
        if (acc_f) begin
            p_i = 8'(ti); p_q = 8'(tq); p_clips = clips;
            p_pow = eni * eni + enq * enq;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        i_enable = 0; i_sym_valid = 0; i_clr_stats = 0; i_noise_on = 0;
        i_noise_valid_I = 0; i_noise_valid_Q = 0;
        repeat (2) @(posedge clock);
        #1;
        i_reset = 1'b1;
        model_zero();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        i_reset = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_symbI !== 8'd0) begin errors++; $display("[TB] FAIL reset_symbI got=%0d exp=0", o_symbI); end
        checks++; if (o_symbQ !== 8'd0) begin errors++; $display("[TB] FAIL reset_symbQ got=%0d exp=0", o_symbQ); end
        checks++; if (o_noise_pow !== 17'd0) begin errors++; $display("[TB] FAIL reset_pow got=%0d exp=0", o_noise_pow); end
        checks++; if (o_pow_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pow_valid got=%b exp=0", o_pow_valid); end
        checks++; if (o_sat_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_sat_count got=%0d exp=0", o_sat_count); end
        do_reset();
    endtask

    task automatic test_pass_through();
        step(1, 1, 64, -32, rand_s8(), rand_s8(), 1, 1, 0, 0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL pass_valid_early got=%b exp=0", o_valid); end
        idle();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL pass_valid got=%b exp=1", o_valid); end
        checks++; if (o_symbI !== 8'd64) begin errors++; $display("[TB] FAIL pass_symbI got=%0d exp=64", $signed(o_symbI)); end
        checks++; if (o_symbQ !== 8'hE0) begin errors++; $display("[TB] FAIL pass_symbQ got=%0d exp=-32", $signed(o_symbQ)); end
        checks++; if (o_sat_count !== 16'd0) begin errors++; $display("[TB] FAIL pass_sat_count got=%0d exp=0", o_sat_count); end
        step(0, 1, 5, 5, 0, 0, 1, 1, 1, 0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL pass_valid_pulse got=%b exp=0", o_valid); end
        checks++; if (o_symbI !== 8'd64) begin errors++; $display("[TB] FAIL pass_hold got=%0d exp=64", $signed(o_symbI)); end
    endtask

    task automatic test_add();
        step(1, 1, 64, -64, 32, -16, 1, 1, 1, 0);
        idle();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got=%b exp=1", o_valid); end
        checks++; if (o_symbI !== 8'd96) begin errors++; $display("[TB] FAIL add_symbI got=%0d exp=96", $signed(o_symbI)); end
        checks++; if (o_symbQ !== 8'hB0) begin errors++; $display("[TB] FAIL add_symbQ got=%0d exp=-80", $signed(o_symbQ)); end
    endtask

    task automatic test_power();
        int pulses;
        logic [16:0] got;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            int ni = (w == 0) ? 64 : -128;
            int nq = (w == 0) ? 0 : -128;
            logic [16:0] exp_pow = (w == 0) ? 17'd4096 : 17'd32768;
            pulses = 0; got = '0;
            for (int n = 0; n <= WIN; n++) begin
                step(n < WIN, 1, 0, 0, ni, nq, 1, 1, 1, 0);
                if (o_pow_valid === 1'b1) begin pulses++; got = o_noise_pow; end
                checks++;
                if (o_pow_valid !== (n == WIN)) begin
                    errors++; $display("[TB] FAIL pow_valid_timing win=%0d n=%0d got=%b exp=%b", w, n, o_pow_valid, n == WIN);
                end
            end
            checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL pow_pulses win=%0d got=%0d exp=1", w, pulses); end
            checks++; if (got !== exp_pow) begin errors++; $display("[TB] FAIL pow_value win=%0d got=%0d exp=%0d", w, got, exp_pow); end
        end
    endtask

    task automatic test_reset_mid_window();
        int pulses;
        for (int n = 0; n < 7; n++) step(1, 1, 127, -128, 64, -64, 1, 1, 1, 0);
        i_reset = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%b exp=0", o_valid); end
        checks++; if (o_symbI !== 8'd0) begin errors++; $display("[TB] FAIL midrst_symbI got=%0d exp=0", o_symbI); end
        checks++; if (o_symbQ !== 8'd0) begin errors++; $display("[TB] FAIL midrst_symbQ got=%0d exp=0", o_symbQ); end
        checks++; if (o_noise_pow !== 17'd0) begin errors++; $display("[TB] FAIL midrst_pow got=%0d exp=0", o_noise_pow); end
        checks++; if (o_sat_count !== 16'd0) begin errors++; $display("[TB] FAIL midrst_sat_count got=%0d exp=0", o_sat_count); end
        do_reset();
        pulses = 0;
        for (int n = 0; n < WIN - 1; n++) begin
            step(1, 1, 0, 0, 64, 0, 1, 1, 1, 0);
            if (o_pow_valid === 1'b1) pulses++;
        end
        idle();
        if (o_pow_valid === 1'b1) pulses++;
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL midrst_early_pulse got=%0d exp=0", pulses); end
        step(1, 1, 0, 0, 64, 0, 1, 1, 1, 0);
        idle();
        checks++; if (o_pow_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pulse got=%b exp=1", o_pow_valid); end
        checks++; if (o_noise_pow !== 17'd4096) begin errors++; $display("[TB] FAIL midrst_pow_value got=%0d exp=4096", o_noise_pow); end
    endtask

    task automatic test_noise_invalid();
        logic [7:0] prev_si;
        prev_si = '0;
        for (int n = 0; n <= WIN; n++) begin
            int si = rand_s8();
            step(n < WIN, 1, si, rand_s8(), 50, rand_s8(), 1, 0, 1, 0);
            if (n >= 1) begin
                checks++;
                if (o_symbI !== prev_si) begin
                    errors++; $display("[TB] FAIL nvalid_symbI n=%0d got=%0d exp=%0d", n, $signed(o_symbI), $signed(prev_si));
                end
            end
            prev_si = 8'(si);
        end
        checks++; if (o_pow_valid !== 1'b1) begin errors++; $display("[TB] FAIL nvalid_pulse got=%b exp=1", o_pow_valid); end
        checks++; if (o_noise_pow !== 17'd0) begin errors++; $display("[TB] FAIL nvalid_pow got=%0d exp=0", o_noise_pow); end
    endtask

    task automatic test_clear();
        int pulses;
        step(1, 1, 127, -128, 127, -128, 1, 1, 1, 0);
        idle();
        idle();
        checks++; if (o_sat_count !== 16'(m_cnt) || m_cnt == 0) begin errors++; $display("[TB] FAIL clr_precount got=%0d exp=%0d", o_sat_count, m_cnt); end
        step(1, 1, 127, -128, 127, -128, 1, 1, 1, 1);
        idle();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_valid got=%b exp=1", o_valid); end
        checks++; if (o_symbI !== 8'd127) begin errors++; $display("[TB] FAIL clr_symbI got=%0d exp=127", $signed(o_symbI)); end
        checks++; if (o_symbQ !== 8'h80) begin errors++; $display("[TB] FAIL clr_symbQ got=%0d exp=-128", $signed(o_symbQ)); end
        idle();
        checks++; if (o_sat_count !== 16'd0) begin errors++; $display("[TB] FAIL clr_sat_count got=%0d exp=0", o_sat_count); end
        pulses = 0;
        for (int n = 0; n <= WIN; n++) begin
            step(n < WIN, 1, 0, 0, 64, 0, 1, 1, 1, 0);
            if (o_pow_valid === 1'b1) begin
                pulses++;
                checks++;
                if (n != WIN || o_noise_pow !== 17'd4096) begin
                    errors++; $display("[TB] FAIL clr_window n=%0d pow=%0d exp n=%0d pow=4096", n, o_noise_pow, WIN);
                end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL clr_window_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int si = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 127 : -128) : rand_s8();
            int sq = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 127 : -128) : rand_s8();
            step($urandom_range(3, 0) != 0, $urandom_range(7, 0) != 0, si, sq, rand_s8(), rand_s8(),
                 $urandom_range(7, 0) != 0, $urandom_range(7, 0) != 0, $urandom_range(7, 0) != 0,
                 $urandom_range(19, 0) == 0);
            checks++; if (o_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid n=%0d got=%b exp=%b", n, o_valid, m_valid); end
            checks++; if (o_symbI !== m_i) begin errors++; $display("[TB] FAIL rnd_symbI n=%0d got=%0d exp=%0d", n, $signed(o_symbI), $signed(m_i)); end
            checks++; if (o_symbQ !== m_q) begin errors++; $display("[TB] FAIL rnd_symbQ n=%0d got=%0d exp=%0d", n, $signed(o_symbQ), $signed(m_q)); end
            checks++; if (o_sat_count !== 16'(m_cnt)) begin errors++; $display("[TB] FAIL rnd_sat_count n=%0d got=%0d exp=%0d", n, o_sat_count, m_cnt); end
            checks++; if (o_pow_valid !== m_pow_valid) begin errors++; $display("[TB] FAIL rnd_pow_valid n=%0d got=%b exp=%b", n, o_pow_valid, m_pow_valid); end
            checks++; if (o_noise_pow !== 17'(m_pow)) begin errors++; $display("[TB] FAIL rnd_pow n=%0d got=%0d exp=%0d", n, o_noise_pow, m_pow); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 1, 127, -128, 127, -128, 1, 1, 1, 0);
        step(1, 1, 127, -128, 127, -128, 1, 1, 1, 0);
        checks++; if (o_symbI !== 8'd127) begin errors++; $display("[TB] FAIL b2b_symbI got=%0d exp=127", $signed(o_symbI)); end
        checks++; if (o_symbQ !== 8'h80) begin errors++; $display("[TB] FAIL b2b_symbQ got=%0d exp=-128", $signed(o_symbQ)); end
        checks++; if (o_sat_count !== 16'd2) begin errors++; $display("[TB] FAIL b2b_first_count got=%0d exp=2", o_sat_count); end
        for (int n = 0; n < 32768; n++) begin
            step(1, 1, 127, -128, 127, -128, 1, 1, 1, 0);
            if (o_valid !== 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL b2b_valid n=%0d got=%b exp=1", n, o_valid);
            end
        end
        idle();
        idle();
        checks++; if (o_sat_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_sat_max got=%0d exp=65535", o_sat_count); end
        checks++; if (o_sat_count !== 16'(m_cnt)) begin errors++; $display("[TB] FAIL b2b_sat_model got=%0d exp=%0d", o_sat_count, m_cnt); end
        repeat (3) step(1, 1, 127, -128, 127, -128, 1, 1, 1, 0);
        idle();
        idle();
        checks++; if (o_sat_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_sat_hold got=%0d exp=65535", o_sat_count); end
    endtask

    initial begin
        model_zero();
        $display("[TB] start");
        test_reset();
        test_pass_through();
        test_add();
        test_power();
        test_reset_mid_window();
        test_noise_invalid();
        test_clear();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
